// File: rtl/chip8_pkg.sv
// Shared CHIP-8 keypad constants: matrix-to-key map, key/row/column counts and
// a lowest-set-key helper.
package chip8_pkg;

  localparam int NUM_KEYS   = 16;
  localparam int MATRIX_DIM = 4;

  // Indexed by row*4+col; row0 = 1,2,3,C  row1 = 4,5,6,D  row2 = 7,8,9,E  row3 = A,0,B,F
  localparam logic [3:0] KEY_MAP [NUM_KEYS] = '{
    4'h1, 4'h2, 4'h3, 4'hC,
    4'h4, 4'h5, 4'h6, 4'hD,
    4'h7, 4'h8, 4'h9, 4'hE,
    4'hA, 4'h0, 4'hB, 4'hF
  };

  function automatic logic [3:0] lowest_key(input logic [NUM_KEYS-1:0] keys);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/chip8_key_debounce.sv
// Sweep-level debounce: compares each completed snapshot with the previous one and
// commits to key_pressed after DEBOUNCE_SCANS identical sweeps. Optional ghost
// rejection is enabled by defining KEYPAD_GHOST_REJECT_EN.
module chip8_key_debounce
  import chip8_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                eval_i,
  input  logic [NUM_KEYS-1:0] snap_i,
  output logic [NUM_KEYS-1:0] key_pressed_o,
  output logic                key_down_o,
  output logic [3:0]          key_code_o
);

  localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS - 1);

  logic [NUM_KEYS-1:0] last_q, last_d;
  logic [NUM_KEYS-1:0] kp_q, kp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                kd_q, kd_d;
  logic [3:0]          kc_q, kc_d;
  logic [NUM_KEYS-1:0] new_keys;
  logic                ghost;

`ifdef KEYPAD_GHOST_REJECT_EN
  // Ghost candidate: two distinct rows share at least two pressed columns.
  function automatic logic is_ghost(input logic [NUM_KEYS-1:0] s);
    logic [MATRIX_DIM-1:0] m [MATRIX_DIM];
    logic g;
    g = 1'b0;
    for (int r = 0; r < MATRIX_DIM; r++)
      for (int c = 0; c < MATRIX_DIM; c++)
        m[r][c] = s[KEY_MAP[r*MATRIX_DIM + c]];
    for (int r1 = 0; r1 < MATRIX_DIM - 1; r1++)
      for (int r2 = r1 + 1; r2 < MATRIX_DIM; r2++)
        if ($countones(m[r1] & m[r2]) >= 2) g = 1'b1;
    return g;
  endfunction

  assign ghost = is_ghost(snap_i);
`else
  assign ghost = 1'b0;
`endif

  assign new_keys = snap_i & ~kp_q;

  // key_down_o is a one-cycle event with no back-pressure; key_code_o is valid
  // with it and holds until the next pulse.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    kp_d   = kp_q;
    kd_d   = 1'b0;
    kc_d   = kc_q;
    if (eval_i) begin
      if (ghost) begin
        cnt_d = '0;
      end else begin
        last_d = snap_i;
        if (snap_i == last_q) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        else                  cnt_d = '0;
        if (cnt_d == CNT_MAX && snap_i != kp_q) begin
          kp_d = snap_i;
          if (|new_keys) begin
            kd_d = 1'b1;
            kc_d = lowest_key(new_keys);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= '0;
      cnt_q  <= '0;
      kp_q   <= '0;
      kd_q   <= 1'b0;
      kc_q   <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      kp_q   <= kp_d;
      kd_q   <= kd_d;
      kc_q   <= kc_d;
    end
  end

  assign key_pressed_o = kp_q;
  assign key_down_o    = kd_q;
  assign key_code_o    = kc_q;

endmodule

// File: rtl/chip8_keypad_scan.sv
// 4x4 hex keypad scanner: row synchroniser, column divider/drive and snapshot
// capture; debounce lives in chip8_key_debounce (KEYPAD_GHOST_REJECT_EN optional).
module chip8_keypad_scan
  import chip8_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] key_pressed,
  output logic        key_down,
  output logic [3:0]  key_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0]       div_q, div_d;
  logic [1:0]          col_q, col_d;
  logic [3:0]          row_s1_q, row_s2_q;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic                sweep_done_q, sweep_done_d;
  logic                div_wrap;

  assign div_wrap = (div_q == DW'(SCAN_DIV - 1));

  // Each column overwrites its own four key bits, so every sweep rewrites snap fully.
  always_comb begin
    div_d        = div_q + DW'(1);
    col_d        = col_q;
    snap_d       = snap_q;
    sweep_done_d = 1'b0;
    if (div_wrap) begin
      div_d        = '0;
      col_d        = col_q + 2'd1;
      sweep_done_d = (col_q == 2'd3);
      for (int r = 0; r < MATRIX_DIM; r++)
        snap_d[KEY_MAP[r*MATRIX_DIM + int'(col_q)]] = ~row_s2_q[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q        <= '0;
      col_q        <= '0;
      row_s1_q     <= 4'hF;
      row_s2_q     <= 4'hF;
      snap_q       <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      col_q        <= col_d;
      row_s1_q     <= row_in;
      row_s2_q     <= row_s1_q;
      snap_q       <= snap_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign col_out = ~(4'b0001 << col_q);

  chip8_key_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .eval_i       (sweep_done_q),
    .snap_i       (snap_q),
    .key_pressed_o(key_pressed),
    .key_down_o   (key_down),
    .key_code_o   (key_code)
  );

endmodule

// File: tb/tb_chip8_keypad_scan.sv
// Bench for chip8_keypad_scan: electrical matrix model, sweep-level reference
// model feeding an expected-event queue, and a negedge monitor.
module tb_chip8_keypad_scan;

  localparam int SD    = 8;
  localparam int DB    = 3;
  localparam int SWEEP = 4 * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] key_pressed;
  logic        key_down;
  logic [3:0]  key_code;

  logic [15:0] held = '0;
  int layout [16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};

  int n_checks = 0;
  int n_pass   = 0;
  int kd_count = 0;
  logic [52:0] exp_q[$];

  // reference model state
  int          edge_n = 0;
  int          j = 0;
  logic        rst_at_edge = 1'b0;
  logic [15:0] h1 = '0, h2 = '0;
  logic [15:0] m_snap = '0, m_prev = '0, m_kp = '0;
  int          m_run = 1;
  logic [3:0]  m_kc = '0;
  logic [15:0] prev_kp = '0;

  chip8_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_pressed(key_pressed),
    .key_down   (key_down),
    .key_code   (key_code)
  );

  always #5 clk = ~clk;

  // Rows pulled low through any chain of pressed switches reaching driven column c.
  function automatic logic [3:0] shorted_rows(input logic [15:0] h, input int c);
    logic [3:0] cl, rl;
    cl = 4'(1 << c);
    rl = '0;
    repeat (4) begin
      for (int r = 0; r < 4; r++)
        for (int cc = 0; cc < 4; cc++)
          if (cl[cc] && h[layout[r*4+cc]]) rl[r] = 1'b1;
      for (int r = 0; r < 4; r++)
        for (int cc = 0; cc < 4; cc++)
          if (rl[r] && h[layout[r*4+cc]]) cl[cc] = 1'b1;
    end
    return rl;
  endfunction

  function automatic logic tb_ghost(input logic [15:0] s);
    logic g;
    g = 1'b0;
    for (int r1 = 0; r1 < 4; r1++)
      for (int r2 = r1 + 1; r2 < 4; r2++)
        for (int c1 = 0; c1 < 4; c1++)
          for (int c2 = c1 + 1; c2 < 4; c2++)
            if (s[layout[r1*4+c1]] && s[layout[r1*4+c2]] &&
                s[layout[r2*4+c1]] && s[layout[r2*4+c2]]) g = 1'b1;
    return g;
  endfunction

  function automatic logic [3:0] lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
    return 4'h0;
  endfunction

  always_comb begin
    row_in = 4'hF;
    if ($countones(~col_out) == 1)
      for (int c = 0; c < 4; c++)
        if (!col_out[c]) row_in = ~shorted_rows(held, c);
  end

  task automatic check(input string name, input logic ok, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: per edge, rebuild snapshots from pad history and debounce by run length.
  always @(posedge clk) begin
    logic [3:0]  rl;
    logic [15:0] nw;
    logic        kd;
    int          c;
    edge_n++;
    rst_at_edge = reset;
    if (!reset) begin
      j = 0; m_snap = '0; m_prev = '0; m_run = 1; m_kp = '0; m_kc = '0;
    end else begin
      if (j % SD == SD - 1) begin
        c  = (j / SD) % 4;
        rl = shorted_rows(h2, c);
        for (int r = 0; r < 4; r++) m_snap[layout[r*4+c]] = rl[r];
      end
      if (j > 0 && j % SWEEP == 0) begin
`ifdef KEYPAD_GHOST_REJECT_EN
        if (tb_ghost(m_snap)) m_run = 1;
        else begin
`else
        begin
`endif
          if (m_snap == m_prev) m_run++;
          else m_run = 1;
          m_prev = m_snap;
          if (m_run >= DB && m_snap != m_kp) begin
            nw = m_snap & ~m_kp;
            kd = (nw != 0);
            if (kd) m_kc = lowest(nw);
            m_kp = m_snap;
            exp_q.push_back({edge_n[31:0], m_kp, kd, m_kc});
          end
        end
      end
      j++;
    end
    h2 = h1;
    h1 = held;
  end

  // Monitor: pops expected commits whenever the DUT shows a change or a pulse.
  always @(negedge clk) begin
    logic [52:0] e;
    if (edge_n > 0) begin
      n_checks++;
      if ($countones(~col_out) == 1) n_pass++;
      else $display("FAIL col_onehot: col_out=%b, required exactly one zero", col_out);
      if (!rst_at_edge) begin
        check("rst_key_pressed", key_pressed == 16'h0, key_pressed, 0);
        check("rst_col_out", col_out == 4'b1110, col_out, 4'b1110);
        check("rst_key_down", key_down == 1'b0, key_down, 0);
        check("rst_key_code", key_code == 4'h0, key_code, 0);
        prev_kp = '0;
      end else begin
        while (exp_q.size() > 0 && int'(exp_q[0][52:21]) < edge_n) begin
          e = exp_q.pop_front();
          n_checks++;
          $display("FAIL missed_commit: DUT did not change, expected kp=%h kd=%b kc=%h at edge %0d",
                   e[20:5], e[4], e[3:0], e[52:21]);
        end
        if (key_down) kd_count++;
        if (key_down || key_pressed != prev_kp) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_commit: kp=%h kd=%b kc=%h at edge %0d, none expected",
                     key_pressed, key_down, key_code, edge_n);
          end else begin
            e = exp_q.pop_front();
            check("commit_event", {edge_n[31:0], key_pressed, key_down, key_code} == e,
                  {edge_n[31:0], key_pressed, key_down, key_code}, e);
          end
        end
        prev_kp = key_pressed;
        check("key_code_track", key_code == m_kc, key_code, m_kc);
      end
    end
  end

  initial begin
    int          k0;
    logic [15:0] m;
    reset = 1'b0;
    held  = '0;
    idle(5);
    check("init_col_out", col_out == 4'b1110, col_out, 4'b1110);
    check("init_key_pressed", key_pressed == 16'h0, key_pressed, 0);
    reset = 1'b1;

    // steady key 5
    idle(10);
    k0 = kd_count;
    held = 16'h0020;
    idle(200);
    check("hold5_kp", key_pressed == 16'h0020, key_pressed, 16'h0020);
    check("hold5_kc", key_code == 4'h5, key_code, 5);
    check("hold5_pulses", kd_count - k0 == 1, kd_count - k0, 1);

    // release: no pulse, code holds
    k0 = kd_count;
    held = '0;
    idle(200);
    check("rel_kp", key_pressed == 16'h0, key_pressed, 0);
    check("rel_kc", key_code == 4'h5, key_code, 5);
    check("rel_pulses", kd_count == k0, kd_count - k0, 0);

    // bounce key 5 every 20 cycles, then steady
    while (j % SWEEP != 3) @(negedge clk);
    k0 = kd_count;
    for (int k = 0; k < 8; k++) begin
      held = (k % 2 == 0) ? 16'h0020 : 16'h0000;
      idle(20);
    end
    held = 16'h0020;
    idle(200);
    check("bounce_kp", key_pressed == 16'h0020, key_pressed, 16'h0020);
    check("bounce_pulses", kd_count - k0 == 1, kd_count - k0, 1);
    held = '0;
    idle(200);

    // keys 0 and A, then add F
    held = 16'h0401;
    idle(200);
    check("k0a_kp", key_pressed == 16'h0401, key_pressed, 16'h0401);
    check("k0a_kc", key_code == 4'h0, key_code, 0);
    held = 16'h8401;
    idle(200);
    check("k0af_kp", key_pressed == 16'h8401, key_pressed, 16'h8401);
    check("k0af_kc", key_code == 4'hF, key_code, 15);
    held = '0;
    idle(200);
    check("clear_kp", key_pressed == 16'h0, key_pressed, 0);

    // keys 1,2,4 produce a ghost 5
    k0 = kd_count;
    held = 16'h0016;
    idle(200);
`ifdef KEYPAD_GHOST_REJECT_EN
    check("ghost_kp", key_pressed == 16'h0, key_pressed, 0);
    check("ghost_pulses", kd_count == k0, kd_count - k0, 0);
`else
    check("ghost_kp", key_pressed == 16'h0036, key_pressed, 16'h0036);
    check("ghost_kc", key_code == 4'h1, key_code, 1);
`endif
    held = '0;
    idle(200);

    // random short presses of one or two keys
    repeat (6) begin
      m = '0;
      repeat ($urandom_range(1, 2)) m[$urandom_range(0, 15)] = 1'b1;
      held = m;
      idle($urandom_range(40, 250));
    end
    held = '0;
    idle(200);
    check("rand_clear_kp", key_pressed == 16'h0, key_pressed, 0);

    // reset mid-sweep with key 5 committed
    held = 16'h0020;
    idle(200);
    check("pre_rst_kp", key_pressed == 16'h0020, key_pressed, 16'h0020);
    idle($urandom_range(1, 30));
    reset = 1'b0;
    @(negedge clk);
    check("midrst_col_out", col_out == 4'b1110, col_out, 4'b1110);
    check("midrst_kp", key_pressed == 16'h0, key_pressed, 0);
    reset = 1'b1;
    idle(200);
    check("recommit_kp", key_pressed == 16'h0020, key_pressed, 16'h0020);
    check("recommit_kc", key_code == 4'h5, key_code, 5);
    held = '0;
    idle(200);

    check("exp_q_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
